// File: rtl/pkt_mon_pkg.sv
// Shared types and helpers for the per-port packet stream monitor.
package pkt_mon_pkg;

  // Framing state of one monitored stream.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } port_state_e;

  // Counter select encodings on the read port; other codes read as zero.
  typedef enum logic [2:0] {
    SEL_PKT      = 3'd0,
    SEL_WORD     = 3'd1,
    SEL_ERR_PKT  = 3'd2,
    SEL_FRM_ERR  = 3'd3,
    SEL_OVERSIZE = 3'd4
  } rd_sel_e;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_W = 64;

  // Increment value, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned       width);
    logic [SAT_W-1:0] max_val;
    max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (value >= max_val) ? value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_port_mon.sv
// One stream's framing FSM, packet length tracker and five saturating
// statistics counters.
module pkt_port_mon
  import pkt_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MAX_PKT_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             beat,
  input  logic             sop,
  input  logic             eop,
  input  logic             err,
  output logic [CNT_W-1:0] cnt_pkt,
  output logic [CNT_W-1:0] cnt_word,
  output logic [CNT_W-1:0] cnt_err_pkt,
  output logic [CNT_W-1:0] cnt_frm_err,
  output logic [CNT_W-1:0] cnt_oversize,
  output logic             frm_err_flag
);

  // Length saturates one past the legal maximum, which is all oversize needs.
  localparam int unsigned   LEN_W   = $clog2(MAX_PKT_WORDS + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_PKT_WORDS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_WORDS);

  port_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic             err_acc_q, err_acc_d;
  logic [CNT_W-1:0] pkt_d, word_d, err_pkt_d, frm_err_d, oversize_d;
  logic             flag_d;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), CNT_W));
  endfunction

  // Next-state and counter-update logic; only accepted beats move anything.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    err_acc_d  = err_acc_q;
    pkt_d      = cnt_pkt;
    word_d     = cnt_word;
    err_pkt_d  = cnt_err_pkt;
    frm_err_d  = cnt_frm_err;
    oversize_d = cnt_oversize;
    flag_d     = frm_err_flag;
    len_inc    = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

    if (clr) begin
      // Clear wins over a same-cycle beat, which is simply dropped.
      state_d    = IDLE;
      len_d      = '0;
      err_acc_d  = 1'b0;
      pkt_d      = '0;
      word_d     = '0;
      err_pkt_d  = '0;
      frm_err_d  = '0;
      oversize_d = '0;
      flag_d     = 1'b0;
    end else if (beat) begin
      if (sop) begin
        // Sop inside a packet abandons it uncounted and flags the gap.
        if (state_q == IN_PKT) begin
          frm_err_d = inc(cnt_frm_err);
          flag_d    = 1'b1;
        end
        word_d = inc(cnt_word);
        if (eop) begin
          pkt_d   = inc(cnt_pkt);
          state_d = IDLE;
          if (err) err_pkt_d = inc(cnt_err_pkt);
        end else begin
          state_d   = IN_PKT;
          len_d     = LEN_W'(1);
          err_acc_d = err;
        end
      end else if (state_q == IDLE) begin
        // Orphan beat: not part of any packet, so no word is counted.
        frm_err_d = inc(cnt_frm_err);
        flag_d    = 1'b1;
      end else begin
        word_d    = inc(cnt_word);
        len_d     = len_inc;
        err_acc_d = err_acc_q | err;
        if (eop) begin
          pkt_d   = inc(cnt_pkt);
          state_d = IDLE;
          if (err_acc_q | err) err_pkt_d = inc(cnt_err_pkt);
          if (len_inc > LEN_MAX) oversize_d = inc(cnt_oversize);
        end
      end
    end
  end

  // State, length and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      err_acc_q    <= 1'b0;
      cnt_pkt      <= '0;
      cnt_word     <= '0;
      cnt_err_pkt  <= '0;
      cnt_frm_err  <= '0;
      cnt_oversize <= '0;
      frm_err_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      len_q        <= len_d;
      err_acc_q    <= err_acc_d;
      cnt_pkt      <= pkt_d;
      cnt_word     <= word_d;
      cnt_err_pkt  <= err_pkt_d;
      cnt_frm_err  <= frm_err_d;
      cnt_oversize <= oversize_d;
      frm_err_flag <= flag_d;
    end
  end

endmodule

// File: rtl/pkt_stream_monitor.sv
// Per-port packet stream monitor: one pkt_port_mon per stream, a registered
// counter read port and a sticky framing-error interrupt.
module pkt_stream_monitor
  import pkt_mon_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned MAX_PKT_WORDS = 256,
  localparam int unsigned RD_PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic [NUM_PORTS-1:0]        iVld,
  input  logic [NUM_PORTS-1:0]        iReady,
  input  logic [NUM_PORTS-1:0]        iSop,
  input  logic [NUM_PORTS-1:0]        iEop,
  input  logic [NUM_PORTS-1:0]        iErr,
  input  logic [NUM_PORTS*DATA_W-1:0] iData,
  input  logic                        iClr,
  input  logic                        iRdReq,
  input  logic [RD_PORT_W-1:0]        iRdPort,
  input  logic [2:0]                  iRdSel,
  output logic                        oRdVld,
  output logic [CNT_W-1:0]            oRdData,
  output logic [NUM_PORTS-1:0]        oFrmErrMask,
  output logic                        oIrq
);

  localparam logic [RD_PORT_W:0] NUM_PORTS_L = (RD_PORT_W + 1)'(NUM_PORTS);

  logic [CNT_W-1:0] cnt_pkt      [NUM_PORTS];
  logic [CNT_W-1:0] cnt_word     [NUM_PORTS];
  logic [CNT_W-1:0] cnt_err_pkt  [NUM_PORTS];
  logic [CNT_W-1:0] cnt_frm_err  [NUM_PORTS];
  logic [CNT_W-1:0] cnt_oversize [NUM_PORTS];
  logic [CNT_W-1:0] rd_mux;
  logic             port_ok;

  // Payload only gives the stream its shape; nothing here inspects it.
  logic unused_data;
  assign unused_data = ^iData;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    pkt_port_mon #(
      .CNT_W        (CNT_W),
      .MAX_PKT_WORDS(MAX_PKT_WORDS)
    ) u_port (
      .clk         (iClk),
      .rst_n       (iRst_n),
      .clr         (iClr),
      .beat        (iVld[g] & iReady[g]),
      .sop         (iSop[g]),
      .eop         (iEop[g]),
      .err         (iErr[g]),
      .cnt_pkt     (cnt_pkt[g]),
      .cnt_word    (cnt_word[g]),
      .cnt_err_pkt (cnt_err_pkt[g]),
      .cnt_frm_err (cnt_frm_err[g]),
      .cnt_oversize(cnt_oversize[g]),
      .frm_err_flag(oFrmErrMask[g])
    );
  end

  assign port_ok = {1'b0, iRdPort} < NUM_PORTS_L;

  // Counter select; unmapped ports and select codes read as zero.
  always_comb begin
    rd_mux = '0;
    if (port_ok) begin
      case (rd_sel_e'(iRdSel))
        SEL_PKT:      rd_mux = cnt_pkt[iRdPort];
        SEL_WORD:     rd_mux = cnt_word[iRdPort];
        SEL_ERR_PKT:  rd_mux = cnt_err_pkt[iRdPort];
        SEL_FRM_ERR:  rd_mux = cnt_frm_err[iRdPort];
        SEL_OVERSIZE: rd_mux = cnt_oversize[iRdPort];
        default:      rd_mux = '0;
      endcase
    end
  end

  // Read register: samples the counters as they stand before this edge's
  // updates, so a read alongside an increment or a clear sees the old value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdVld  <= 1'b0;
      oRdData <= '0;
    end else begin
      oRdVld <= iRdReq;
      if (iRdReq) oRdData <= rd_mux;
    end
  end

  assign oIrq = |oFrmErrMask;

endmodule

// File: tb/tb_pkt_stream_monitor.sv
// Directed bench for pkt_stream_monitor: a 16-port 32-bit-counter instance
// and a 3-port 4-bit-counter instance for saturation and out-of-range reads.
module tb_pkt_stream_monitor;

  localparam int A_PORTS = 16;
  localparam int B_PORTS = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A
  logic [A_PORTS-1:0]    a_vld, a_rdy, a_sop, a_eop, a_err, a_mask;
  logic [A_PORTS*32-1:0] a_data;
  logic                  a_clr, a_rd_req, a_rd_vld, a_irq;
  logic [3:0]            a_rd_port;
  logic [2:0]            a_rd_sel;
  logic [31:0]           a_rd_data;

  // Instance B
  logic [B_PORTS-1:0]    b_vld, b_rdy, b_sop, b_eop, b_err, b_mask;
  logic [B_PORTS*8-1:0]  b_data;
  logic                  b_clr, b_rd_req, b_rd_vld, b_irq;
  logic [1:0]            b_rd_port;
  logic [2:0]            b_rd_sel;
  logic [3:0]            b_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  pkt_stream_monitor #(
    .NUM_PORTS(A_PORTS), .DATA_W(32), .CNT_W(32), .MAX_PKT_WORDS(256)
  ) u_dut_a (
    .iClk(clk), .iRst_n(rst_n), .iVld(a_vld), .iReady(a_rdy), .iSop(a_sop),
    .iEop(a_eop), .iErr(a_err), .iData(a_data), .iClr(a_clr),
    .iRdReq(a_rd_req), .iRdPort(a_rd_port), .iRdSel(a_rd_sel),
    .oRdVld(a_rd_vld), .oRdData(a_rd_data), .oFrmErrMask(a_mask), .oIrq(a_irq)
  );

  pkt_stream_monitor #(
    .NUM_PORTS(B_PORTS), .DATA_W(8), .CNT_W(4), .MAX_PKT_WORDS(4)
  ) u_dut_b (
    .iClk(clk), .iRst_n(rst_n), .iVld(b_vld), .iReady(b_rdy), .iSop(b_sop),
    .iEop(b_eop), .iErr(b_err), .iData(b_data), .iClr(b_clr),
    .iRdReq(b_rd_req), .iRdPort(b_rd_port), .iRdSel(b_rd_sel),
    .oRdVld(b_rd_vld), .oRdData(b_rd_data), .oFrmErrMask(b_mask), .oIrq(b_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs set before the call are sampled at this edge and
  // outputs are looked at 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input int p, input bit sop, input bit eop, input bit err);
    a_vld[p] = 1'b1; a_sop[p] = sop; a_eop[p] = eop; a_err[p] = err;
    step();
    a_vld = '0; a_sop = '0; a_eop = '0; a_err = '0;
  endtask

  task automatic a_pkt(input int p, input int len, input int err_at);
    for (int i = 0; i < len; i++) a_beat(p, i == 0, i == len - 1, i == err_at);
  endtask

  task automatic a_read(input int p, input int sel, input logic [31:0] exp, input string tag);
    a_rd_port = p[3:0]; a_rd_sel = sel[2:0]; a_rd_req = 1'b1;
    step();
    a_rd_req = 1'b0;
    check({tag, "_vld"}, 32'(a_rd_vld), 32'd1);
    check(tag, a_rd_data, exp);
  endtask

  task automatic b_beat(input int p, input bit sop, input bit eop);
    b_vld[p] = 1'b1; b_sop[p] = sop; b_eop[p] = eop;
    step();
    b_vld = '0; b_sop = '0; b_eop = '0;
  endtask

  task automatic b_read(input int p, input int sel, input logic [31:0] exp, input string tag);
    b_rd_port = p[1:0]; b_rd_sel = sel[2:0]; b_rd_req = 1'b1;
    step();
    b_rd_req = 1'b0;
    check({tag, "_vld"}, 32'(b_rd_vld), 32'd1);
    check(tag, 32'(b_rd_data), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    a_vld = '0; a_rdy = '1; a_sop = '0; a_eop = '0; a_err = '0; a_data = '0;
    a_clr = 1'b0; a_rd_req = 1'b0; a_rd_port = '0; a_rd_sel = '0;
    b_vld = '0; b_rdy = '1; b_sop = '0; b_eop = '0; b_err = '0; b_data = '0;
    b_clr = 1'b0; b_rd_req = 1'b0; b_rd_port = '0; b_rd_sel = '0;

    // Reset state
    step(); step();
    check("rst_rd_vld",  32'(a_rd_vld), 32'd0);
    check("rst_rd_data", a_rd_data, 32'd0);
    check("rst_mask",    32'(a_mask), 32'd0);
    check("rst_irq",     32'(a_irq), 32'd0);
    check("rst_b_irq",   32'(b_irq), 32'd0);
    rst_n = 1'b1;
    step();
    a_read(4, 0, 32'd0, "rst_pkt4");

    // Port 3: packets of 1, 4 and 256 beats (256 is still legal)
    a_pkt(3, 1, -1);
    a_pkt(3, 4, -1);
    a_pkt(3, 256, -1);
    a_read(3, 0, 32'd3,   "p3_pkt");
    a_read(3, 1, 32'd261, "p3_word");
    a_read(3, 4, 32'd0,   "p3_oversize");
    a_read(3, 3, 32'd0,   "p3_frm");
    a_read(3, 2, 32'd0,   "p3_errpkt");
    a_read(3, 5, 32'd0,   "p3_sel5");
    a_read(3, 7, 32'd0,   "p3_sel7");

    // Port 0: 257 beats, error flagged on beat 10
    a_pkt(0, 257, 10);
    a_read(0, 0, 32'd1,   "p0_pkt");
    a_read(0, 2, 32'd1,   "p0_errpkt");
    a_read(0, 4, 32'd1,   "p0_oversize");
    a_read(0, 1, 32'd257, "p0_word");

    // Port 5: Sop + 1 beat, then Sop restarts and the new packet ends on beat 3
    check("p5_irq_before", 32'(a_irq), 32'd0);
    a_beat(5, 1, 0, 0);
    a_beat(5, 0, 0, 0);
    a_beat(5, 1, 0, 0);
    a_beat(5, 0, 0, 0);
    a_beat(5, 0, 1, 0);
    a_read(5, 3, 32'd1, "p5_frm");
    a_read(5, 0, 32'd1, "p5_pkt");
    a_read(5, 1, 32'd5, "p5_word");
    check("p5_mask", 32'(a_mask), 32'h0020);
    check("p5_irq",  32'(a_irq), 32'd1);

    // Port 7: orphan beat
    a_beat(7, 0, 0, 0);
    a_read(7, 3, 32'd1, "p7_frm");
    a_read(7, 1, 32'd0, "p7_word");
    check("p7_mask", 32'(a_mask), 32'h00A0);

    // Port 6: 10 stalled cycles, then one accepted single-beat packet with a
    // same-cycle read, followed by a back-to-back read
    a_rdy[6] = 1'b0; a_vld[6] = 1'b1; a_sop[6] = 1'b1; a_eop[6] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    a_rdy[6] = 1'b1;
    a_rd_port = 4'd6; a_rd_sel = 3'd0; a_rd_req = 1'b1;
    step();
    a_vld = '0; a_sop = '0; a_eop = '0;
    check("p6_same_vld", 32'(a_rd_vld), 32'd1);
    check("p6_same_cyc", a_rd_data, 32'd0);
    step();
    a_rd_req = 1'b0;
    check("p6_b2b_vld", 32'(a_rd_vld), 32'd1);
    check("p6_next_cyc", a_rd_data, 32'd1);
    step();
    check("rd_vld_drop", 32'(a_rd_vld), 32'd0);
    check("rd_data_hold", a_rd_data, 32'd1);
    a_read(6, 1, 32'd1, "p6_word");

    // Instance B: 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) b_beat(1, 1, 1);
    b_read(1, 0, 32'd15, "b1_pkt_sat");
    b_read(1, 1, 32'd15, "b1_word_sat");
    b_beat(0, 0, 0);
    check("b_irq_set", 32'(b_irq), 32'd1);
    b_read(3, 0, 32'd0, "b_port_oor");
    // Clear with a same-cycle read and beat: read sees pre-clear, beat dropped
    b_clr = 1'b1; b_rd_req = 1'b1; b_rd_port = 2'd1; b_rd_sel = 3'd0;
    b_vld[1] = 1'b1; b_sop[1] = 1'b1; b_eop[1] = 1'b1;
    step();
    b_clr = 1'b0; b_rd_req = 1'b0; b_vld = '0; b_sop = '0; b_eop = '0;
    check("b_clr_preval", 32'(b_rd_data), 32'd15);
    check("b_clr_irq",  32'(b_irq), 32'd0);
    check("b_clr_mask", 32'(b_mask), 32'd0);
    b_read(1, 0, 32'd0, "b1_pkt_clr");
    b_read(1, 1, 32'd0, "b1_word_clr");
    b_read(0, 3, 32'd0, "b0_frm_clr");

    // Port 2 of A: reset mid-packet, then a continuing beat is an orphan
    a_beat(2, 1, 0, 0);
    a_beat(2, 0, 0, 0);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    check("mid_rst_mask",    32'(a_mask), 32'd0);
    check("mid_rst_rd_data", a_rd_data, 32'd0);
    a_beat(2, 0, 0, 0);
    a_read(2, 3, 32'd1, "p2_frm");
    a_read(2, 1, 32'd0, "p2_word");
    a_read(2, 0, 32'd0, "p2_pkt");
    a_read(3, 0, 32'd0, "p3_pkt_after_rst");
    check("p2_mask", 32'(a_mask), 32'h0004);
    check("p2_irq",  32'(a_irq), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
